// File: rtl/inst_mem_loadable.sv
// inst_mem_loadable: run-time loadable instruction memory for the fetch stage.
//
// Two-state FSM (RUN / LOAD). In RUN the fetch port is open and returns one
// word per cycle with a single cycle of registered read latency. In LOAD the
// fetch port is closed and words from the sequential load port are written
// from index 0 upward. Writes past the end are dropped and set a sticky error.
//
// Optional feature macro: IMEM_BOUNDS_CHECK_EN
//   defined   : misaligned or out-of-range fetches return 0 with fetch_fault=1
//   undefined : fetch index wraps modulo DEPTH, fetch_fault tied to 0
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   fetch_req/addr      fetch request and byte address
//   fetch_ready         request accepted this cycle (high in RUN)
//   fetch_valid/instr   fetched word, one cycle after an accepted request
//   fetch_fault         address fault, qualified by fetch_valid
//   load_start          pulse: begin (or restart) a program load
//   load_valid/data     next program word
//   load_last           final word marker, qualified by load_valid
//   load_busy           high while loading
//   load_done           one-cycle pulse when a load completes
//   load_err            sticky overflow flag
//   load_count          words written by the last or current load
module inst_mem_loadable #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fetch_req,
  input  logic [31:0]                fetch_addr,
  output logic                       fetch_ready,
  output logic                       fetch_valid,
  output logic [DATA_W-1:0]          fetch_instr,
  output logic                       fetch_fault,
  input  logic                       load_start,
  input  logic                       load_valid,
  input  logic [DATA_W-1:0]          load_data,
  input  logic                       load_last,
  output logic                       load_busy,
  output logic                       load_done,
  output logic                       load_err,
  output logic [$clog2(DEPTH):0]     load_count
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  typedef enum logic {
    RUN_S  = 1'b0,
    LOAD_S = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic                 load_err_q, load_err_d;
  logic                 load_done_q, load_done_d;
  logic                 load_busy_q, load_busy_d;
  logic                 fetch_ready_q, fetch_ready_d;
  logic                 fetch_valid_q, fetch_valid_d;
  logic [DATA_W-1:0]    fetch_instr_q, fetch_instr_d;
  logic                 fetch_fault_q, fetch_fault_d;

  logic [DATA_W-1:0]    mem_q [DEPTH];
  logic                 mem_we_c;
  logic [IDX_W-1:0]     fetch_idx_c;
  logic                 addr_fault_c;

  assign fetch_idx_c = fetch_addr[IDX_W+1:2];

  // Address fault decode for the optional bounds check.
`ifdef IMEM_BOUNDS_CHECK_EN
  assign addr_fault_c = (fetch_addr[1:0] != 2'b00) ||
                        (fetch_addr[31:2] >= 30'(DEPTH));
`else
  logic unused_addr_c;
  assign addr_fault_c  = 1'b0;
  assign unused_addr_c = ^{fetch_addr[31:IDX_W+2], fetch_addr[1:0]};
`endif

  // Next-state, load pointer and fetch pipeline logic.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    load_err_d    = load_err_q;
    load_done_d   = 1'b0;
    fetch_valid_d = 1'b0;
    fetch_instr_d = fetch_instr_q;
    fetch_fault_d = 1'b0;
    mem_we_c      = 1'b0;

    case (state_q)
      RUN_S: begin
        // A fetch in the same cycle as load_start still sees the old image.
        if (fetch_req) begin
          fetch_valid_d = 1'b1;
          fetch_fault_d = addr_fault_c;
          fetch_instr_d = addr_fault_c ? '0 : mem_q[fetch_idx_c];
        end
        if (load_start) begin
          state_d    = LOAD_S;
          wr_ptr_d   = '0;
          load_err_d = 1'b0;
        end
      end

      LOAD_S: begin
        if (load_start) begin
          wr_ptr_d   = '0;
          load_err_d = 1'b0;
        end else if (load_valid) begin
          // MSB of the pointer set means the memory is full: drop the word.
          if (!wr_ptr_q[IDX_W]) begin
            mem_we_c = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
          end else begin
            load_err_d = 1'b1;
          end
          if (load_last) begin
            state_d     = RUN_S;
            load_done_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = RUN_S;
      end
    endcase

    fetch_ready_d = (state_d == RUN_S);
    load_busy_d   = (state_d == LOAD_S);
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= RUN_S;
      wr_ptr_q      <= '0;
      load_err_q    <= 1'b0;
      load_done_q   <= 1'b0;
      load_busy_q   <= 1'b0;
      fetch_ready_q <= 1'b1;
      fetch_valid_q <= 1'b0;
      fetch_instr_q <= '0;
      fetch_fault_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      load_err_q    <= load_err_d;
      load_done_q   <= load_done_d;
      load_busy_q   <= load_busy_d;
      fetch_ready_q <= fetch_ready_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_instr_q <= fetch_instr_d;
      fetch_fault_q <= fetch_fault_d;
    end
  end

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[wr_ptr_q[IDX_W-1:0]] <= load_data;
    end
  end

  assign fetch_ready = fetch_ready_q;
  assign fetch_valid = fetch_valid_q;
  assign fetch_instr = fetch_instr_q;
  assign fetch_fault = fetch_fault_q;
  assign load_busy   = load_busy_q;
  assign load_done   = load_done_q;
  assign load_err    = load_err_q;
  assign load_count  = wr_ptr_q;

endmodule

// File: tb/tb_inst_mem_loadable.sv
// Self-checking bench for inst_mem_loadable (DATA_W=32, DEPTH=64).
// Expected fetch results are pushed into a queue from a reference image when
// a request is driven, and popped by a monitor whenever fetch_valid is seen.
module tb_inst_mem_loadable;

  localparam int DEPTH = 64;

  logic        clk;
  logic        rst;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic        fetch_fault;
  logic        load_start;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_busy;
  logic        load_done;
  logic        load_err;
  logic [6:0]  load_count;

  inst_mem_loadable #(.DATA_W(32), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .fetch_fault (fetch_fault),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_busy   (load_busy),
    .load_done   (load_done),
    .load_err    (load_err),
    .load_count  (load_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic [31:0] model_mem [DEPTH];
  int          mptr;
  logic        merr;
  logic [32:0] exp_q [$];
  logic [32:0] mon_e;

  // Reference fetch result: {fault, instr}.
  function automatic logic [32:0] exp_fetch(input logic [31:0] a);
`ifdef IMEM_BOUNDS_CHECK_EN
    if (a[1:0] != 2'b00 || a[31:2] >= 30'(DEPTH)) return {1'b1, 32'h0};
`endif
    return {1'b0, model_mem[a[7:2]]};
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (fetch_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL fetch_unexpected: fetch_valid=1 required 0 (instr=%h)", fetch_instr);
      end else begin
        mon_e = exp_q.pop_front();
        if ({fetch_fault, fetch_instr} !== mon_e) begin
          errors++;
          $display("FAIL fetch_data: got fault=%b instr=%h required fault=%b instr=%h",
                   fetch_fault, fetch_instr, mon_e[32], mon_e[31:0]);
        end
      end
    end
    if (load_done === 1'b1) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] a);
    fetch_req  = 1'b1;
    fetch_addr = a;
    exp_q.push_back(exp_fetch(a));
    tick();
  endtask

  task automatic fetch_drain(input string name);
    fetch_req = 1'b0;
    tick();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_valid: %0d fetches outstanding required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic start_load();
    load_start = 1'b1;
    mptr = 0;
    merr = 1'b0;
    tick();
    load_start = 1'b0;
    checks++;
    if (load_busy !== 1'b1 || fetch_ready !== 1'b0 || load_err !== 1'b0 || load_count !== 7'd0) begin
      errors++;
      $display("FAIL start_load: busy=%b ready=%b err=%b count=%0d required 1 0 0 0",
               load_busy, fetch_ready, load_err, load_count);
    end
  endtask

  task automatic load_word(input logic [31:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    if (mptr < DEPTH) begin
      model_mem[mptr] = d;
      mptr++;
    end else begin
      merr = 1'b1;
    end
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic check_load_end(input string name, input int done_before);
    checks++;
    if (load_done !== 1'b1 || load_busy !== 1'b0 || fetch_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_end: done=%b busy=%b ready=%b required 1 0 1",
               name, load_done, load_busy, fetch_ready);
    end
    checks++;
    if (load_count !== 7'(mptr) || load_err !== merr) begin
      errors++;
      $display("FAIL %s_status: count=%0d err=%b required %0d %b",
               name, load_count, load_err, mptr, merr);
    end
    tick();
    checks++;
    if (load_done !== 1'b0 || done_cnt != done_before + 1) begin
      errors++;
      $display("FAIL %s_done_pulse: done=%b pulses=%0d required 0 %0d",
               name, load_done, done_cnt - done_before, 1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    checks++;
    if (fetch_valid !== 1'b0 || fetch_instr !== 32'h0 || fetch_fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_fetch: valid=%b instr=%h fault=%b required 0 0 0",
               fetch_valid, fetch_instr, fetch_fault);
    end
    checks++;
    if (load_busy !== 1'b0 || load_done !== 1'b0 || load_err !== 1'b0 || load_count !== 7'd0) begin
      errors++;
      $display("FAIL reset_load: busy=%b done=%b err=%b count=%0d required 0 0 0 0",
               load_busy, load_done, load_err, load_count);
    end
    checks++;
    if (fetch_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b required 1", fetch_ready);
    end
  endtask

  task automatic test_load_fetch();
    int d0;
    d0 = done_cnt;
    start_load();
    load_word(32'hE3A00014, 1'b0);
    load_word(32'hE3A01A01, 1'b0);
    load_word(32'hE3A02103, 1'b1);
    check_load_end("basic_load", d0);
    do_fetch(32'h0);
    do_fetch(32'h4);
    do_fetch(32'h8);
    fetch_drain("basic_fetch");
  endtask

  task automatic test_fetch_during_load();
    int d0;
    d0 = done_cnt;
    fetch_req  = 1'b1;
    fetch_addr = 32'h4;
    exp_q.push_back(exp_fetch(32'h4));
    start_load();
    // fetch_req held high through the load: nothing may be accepted.
    fetch_addr = 32'h8;
    for (int i = 0; i < 3; i++) begin
      load_word(32'h5550_0000 + 32'(i), (i == 2));
      if (i < 2) begin
        checks++;
        if (fetch_ready !== 1'b0) begin
          errors++;
          $display("FAIL load_ready: got %b required 0", fetch_ready);
        end
      end else begin
        fetch_req = 1'b0;
      end
    end
    check_load_end("overlap_load", d0);
    do_fetch(32'h4);
    fetch_drain("overlap_fetch");
  endtask

  task automatic test_overflow();
    int d0;
    d0 = done_cnt;
    start_load();
    for (int i = 0; i < 66; i++) load_word(32'hA000_0000 + 32'(i), (i == 65));
    check_load_end("overflow", d0);
    checks++;
    if (load_err !== 1'b1 || load_count !== 7'd64) begin
      errors++;
      $display("FAIL overflow_flags: err=%b count=%0d required 1 64", load_err, load_count);
    end
    do_fetch(32'hFC);
    do_fetch(32'h0);
    fetch_drain("overflow_fetch");
  endtask

  task automatic test_bounds();
    do_fetch(32'h100);
`ifdef IMEM_BOUNDS_CHECK_EN
    do_fetch(32'h6);
`endif
    do_fetch(32'h10);
    fetch_drain("bounds");
  endtask

  task automatic test_reset_mid_load();
    int d0;
    start_load();
    load_word(32'h2222_0000, 1'b0);
    load_word(32'h2222_0001, 1'b0);
    d0 = done_cnt;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    mptr = 0;
    merr = 1'b0;
    checks++;
    if (load_busy !== 1'b0 || load_done !== 1'b0 || fetch_ready !== 1'b1 || load_count !== 7'd0) begin
      errors++;
      $display("FAIL reset_mid_load: busy=%b done=%b ready=%b count=%0d required 0 0 1 0",
               load_busy, load_done, fetch_ready, load_count);
    end
    tick();
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("FAIL reset_mid_done: pulses=%0d required 0", done_cnt - d0);
    end
    do_fetch(32'h4);
    do_fetch(32'h8);
    fetch_drain("reset_mid_fetch");
  endtask

  task automatic test_restart();
    int d0;
    start_load();
    for (int i = 0; i < 3; i++) load_word(32'h3333_0000 + 32'(i), 1'b0);
    checks++;
    if (load_count !== 7'd3) begin
      errors++;
      $display("FAIL restart_pre_count: got %0d required 3", load_count);
    end
    d0 = done_cnt;
    start_load();
    load_word(32'h4444_0000, 1'b0);
    load_word(32'h4444_0001, 1'b1);
    check_load_end("restart", d0);
    do_fetch(32'h0);
    do_fetch(32'h4);
    do_fetch(32'h8);
    fetch_drain("restart_fetch");
  endtask

  initial begin
    rst        = 1'b0;
    fetch_req  = 1'b0;
    fetch_addr = 32'h0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_data  = 32'h0;
    load_last  = 1'b0;
    mptr       = 0;
    merr       = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;

    test_reset();
    test_load_fetch();
    test_fetch_during_load();
    test_overflow();
    test_bounds();
    test_reset_mid_load();
    test_restart();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
